// File: rtl/time_entry_pkg.sv
// Shared types, limits and the BCD helper for the time-entry block.
package time_entry_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_EDIT_HR  = 3'd1,
      ST_EDIT_MIN = 3'd2,
      ST_EDIT_SEC = 3'd3,
      ST_LOAD     = 3'd4
   } state_t;

   localparam logic [6:0] HR_MAX = 7'd23;
   localparam logic [6:0] MS_MAX = 7'd59;

   localparam logic [1:0] FS_NONE = 2'b00;
   localparam logic [1:0] FS_HR   = 2'b01;
   localparam logic [1:0] FS_MIN  = 2'b10;
   localparam logic [1:0] FS_SEC  = 2'b11;

   typedef struct packed {
      logic       valid;
      logic [6:0] value;
   } bcd_result_t;

   // Two BCD digits to binary, checked against an upper limit. The value is
   // only meaningful when valid is set; legal inputs never exceed 99, so
   // seven bits hold the full result before the caller narrows it.
   function automatic bcd_result_t bcd_to_bin(input logic [7:0] bcd,
                                              input logic [6:0] max_val);
      bcd_result_t res;
      logic [6:0]  tens;
      logic [6:0]  units;
      tens      = {3'b000, bcd[7:4]};
      units     = {3'b000, bcd[3:0]};
      res.value = tens * 7'd10 + units;
      res.valid = (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9) && (res.value <= max_val);
      return res;
   endfunction

endpackage

// File: rtl/time_entry_key_edge.sv
// Key conditioner: two-flop synchronizer followed by a rising-edge detector.
// A held key yields a single one-cycle press pulse.
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic key_i,
   output logic press_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Synchronize the raw button level and remember the previous synced value.
   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // prev starts at 0 after reset, so a key held through reset still fires once.
   assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/time_entry.sv
// Time-entry front end: walks the user through hours, minutes and seconds
// from BCD switches, then offers the result to the clock counter.
module time_entry
   import time_entry_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_enter,
   input  logic       key_cancel,
   input  logic [7:0] sw_bcd,
   input  logic       load_ready,
   output logic       load_valid,
   output logic [4:0] load_hr,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic       edit_active,
   output logic [1:0] field_sel,
   output logic       err
);

   logic        enter_evt;
   logic        cancel_evt;

   state_t      state_q, state_d;
   logic [4:0]  hr_q, hr_d;
   logic [5:0]  min_q, min_d;
   logic [5:0]  sec_q, sec_d;
   logic        err_q, err_d;

   logic [6:0]  field_max;
   bcd_result_t conv;

   key_edge u_enter (
      .clk     (clk),
      .rst     (rst),
      .key_i   (key_enter),
      .press_o (enter_evt)
   );

   key_edge u_cancel (
      .clk     (clk),
      .rst     (rst),
      .key_i   (key_cancel),
      .press_o (cancel_evt)
   );

   // The hours field has a tighter limit than minutes and seconds.
   assign field_max = (state_q == ST_EDIT_HR) ? HR_MAX : MS_MAX;
   assign conv      = bcd_to_bin(sw_bcd, field_max);

   // State and captured fields; everything clears asynchronously on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hr_q    <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hr_q    <= hr_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         err_q   <= err_d;
      end
   end

   // Next-state and field-capture logic; cancel takes priority over enter.
   always_comb begin
      // NOTE: every variable gets a hold default first so no path infers a latch.
      state_d = state_q;
      hr_d    = hr_q;
      min_d   = min_q;
      sec_d   = sec_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (enter_evt) state_d = ST_EDIT_HR;
         end

         ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC: begin
            if (cancel_evt) begin
               state_d = ST_IDLE;
               hr_d    = '0;
               min_d   = '0;
               sec_d   = '0;
               err_d   = 1'b0;
            end else if (enter_evt) begin
               if (conv.valid) begin
                  err_d = 1'b0;
                  unique case (state_q)
                     ST_EDIT_HR: begin
                        hr_d    = conv.value[4:0];
                        state_d = ST_EDIT_MIN;
                     end
                     ST_EDIT_MIN: begin
                        min_d   = conv.value[5:0];
                        state_d = ST_EDIT_SEC;
                     end
                     default: begin
                        sec_d   = conv.value[5:0];
                        state_d = ST_LOAD;
                     end
                  endcase
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_LOAD: begin
            if (load_ready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs decoded only from the registered state.
   always_comb begin
      edit_active = 1'b0;
      field_sel   = FS_NONE;
      load_valid  = 1'b0;
      unique case (state_q)
         ST_EDIT_HR: begin
            edit_active = 1'b1;
            field_sel   = FS_HR;
         end
         ST_EDIT_MIN: begin
            edit_active = 1'b1;
            field_sel   = FS_MIN;
         end
         ST_EDIT_SEC: begin
            edit_active = 1'b1;
            field_sel   = FS_SEC;
         end
         ST_LOAD:  load_valid = 1'b1;
         default:  ;
      endcase
   end

   assign load_hr  = hr_q;
   assign load_min = min_q;
   assign load_sec = sec_q;
   assign err      = err_q;

endmodule

// File: tb/tb_time_entry.sv
// Directed self-checking bench for time_entry.
module tb_time_entry;

   logic       clk;
   logic       rst;
   logic       key_enter;
   logic       key_cancel;
   logic [7:0] sw_bcd;
   logic       load_ready;
   logic       load_valid;
   logic [4:0] load_hr;
   logic [5:0] load_min;
   logic [5:0] load_sec;
   logic       edit_active;
   logic [1:0] field_sel;
   logic       err;

   int n_checks = 0;
   int n_pass   = 0;
   int lv_count = 0;
   int hs_count = 0;

   time_entry dut (
      .clk         (clk),
      .rst         (rst),
      .key_enter   (key_enter),
      .key_cancel  (key_cancel),
      .sw_bcd      (sw_bcd),
      .load_ready  (load_ready),
      .load_valid  (load_valid),
      .load_hr     (load_hr),
      .load_min    (load_min),
      .load_sec    (load_sec),
      .edit_active (edit_active),
      .field_sel   (field_sel),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles with load_valid high and completed handshakes.
   always @(posedge clk) begin
      if (load_valid) lv_count <= lv_count + 1;
      if (load_valid && load_ready) hs_count <= hs_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Press (and release) keys with the switches set; returns once the
   // synchronizers have settled so the next press is seen as a new event.
   task automatic press(input logic [7:0] sw, input logic e, input logic c);
      @(negedge clk);
      sw_bcd     = sw;
      key_enter  = e;
      key_cancel = c;
      repeat (3) @(posedge clk);
      @(negedge clk);
      key_enter  = 1'b0;
      key_cancel = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " load_valid"},  32'(load_valid),  32'd0);
      check({tag, " load_hr"},     32'(load_hr),     32'd0);
      check({tag, " load_min"},    32'(load_min),    32'd0);
      check({tag, " load_sec"},    32'(load_sec),    32'd0);
      check({tag, " edit_active"}, 32'(edit_active), 32'd0);
      check({tag, " field_sel"},   32'(field_sel),   32'd0);
      check({tag, " err"},         32'(err),         32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      key_enter  = 1'b0;
      key_cancel = 1'b0;
      sw_bcd     = 8'h00;
      load_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Press timing and single event for a long hold.
      sw_bcd    = 8'h12;
      key_enter = 1'b1;
      @(negedge clk);
      check("edge1 idle", 32'(edit_active), 32'd0);
      @(negedge clk);
      check("edge2 idle", 32'(edit_active), 32'd0);
      @(negedge clk);
      check("edge3 edit", 32'(edit_active), 32'd1);
      check("edge3 fsel", 32'(field_sel),   32'd1);
      repeat (97) @(negedge clk);
      check("hold fsel", 32'(field_sel), 32'd1);
      check("hold hr",   32'(load_hr),   32'd0);
      key_enter = 1'b0;
      repeat (3) @(negedge clk);
      check("release fsel", 32'(field_sel), 32'd1);

      // Hours limit.
      press(8'h24, 1'b1, 1'b0);
      check("hr24 err",  32'(err),       32'd1);
      check("hr24 fsel", 32'(field_sel), 32'd1);
      press(8'h23, 1'b1, 1'b0);
      check("hr23 err",  32'(err),       32'd0);
      check("hr23 fsel", 32'(field_sel), 32'd2);
      check("hr23 val",  32'(load_hr),   32'd23);

      // Minutes: bad digit, over limit, then the top legal value.
      press(8'h5A, 1'b1, 1'b0);
      check("min5A err",  32'(err),       32'd1);
      check("min5A fsel", 32'(field_sel), 32'd2);
      check("min5A val",  32'(load_min),  32'd0);
      press(8'h60, 1'b1, 1'b0);
      check("min60 err",  32'(err),       32'd1);
      press(8'h59, 1'b1, 1'b0);
      check("min59 err",  32'(err),       32'd0);
      check("min59 fsel", 32'(field_sel), 32'd3);
      check("min59 val",  32'(load_min),  32'd59);

      // Enter plus cancel together in EDIT_SEC: cancel wins, fields discarded.
      press(8'h30, 1'b1, 1'b1);
      check_all_zero("cancel");
      check("cancel no load", 32'(lv_count), 32'd0);

      // Cancel alone in IDLE is ignored.
      press(8'h00, 1'b0, 1'b1);
      check("idle cancel", 32'(edit_active), 32'd0);

      // Full entry and handshake.
      press(8'h00, 1'b1, 1'b0);
      check("entry start", 32'(field_sel), 32'd1);
      press(8'h13, 1'b1, 1'b0);
      press(8'h45, 1'b1, 1'b0);
      press(8'h07, 1'b1, 1'b0);
      check("load valid", 32'(load_valid),  32'd1);
      check("load hr",    32'(load_hr),     32'd13);
      check("load min",   32'(load_min),    32'd45);
      check("load sec",   32'(load_sec),    32'd7);
      check("load edit",  32'(edit_active), 32'd0);
      check("load fsel",  32'(field_sel),   32'd0);
      press(8'h11, 1'b1, 1'b1);
      check("load keys ignored", 32'(load_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall valid", 32'(load_valid), 32'd1);
      end
      check("stall hr",  32'(load_hr),  32'd13);
      check("stall min", 32'(load_min), 32'd45);
      check("stall sec", 32'(load_sec), 32'd7);
      load_ready = 1'b1;
      @(negedge clk);
      load_ready = 1'b0;
      check("hs valid low", 32'(load_valid), 32'd0);
      check("hs count",     32'(hs_count),   32'd1);
      check("hold hr",      32'(load_hr),    32'd13);
      check("hold min",     32'(load_min),   32'd45);
      check("hold sec",     32'(load_sec),   32'd7);
      repeat (3) @(negedge clk);
      check("hs once", 32'(hs_count), 32'd1);

      // Asynchronous reset while offering a load, key held through reset.
      press(8'h00, 1'b1, 1'b0);
      press(8'h08, 1'b1, 1'b0);
      press(8'h30, 1'b1, 1'b0);
      press(8'h59, 1'b1, 1'b0);
      check("load2 valid", 32'(load_valid), 32'd1);
      check("load2 hr",    32'(load_hr),    32'd8);
      @(negedge clk);
      key_enter = 1'b1;
      #2 rst = 1'b1;
      #1;
      check_all_zero("async rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post rst e1", 32'(edit_active), 32'd0);
      @(negedge clk);
      check("post rst e2", 32'(edit_active), 32'd0);
      @(negedge clk);
      check("post rst e3", 32'(edit_active), 32'd1);
      key_enter = 1'b0;
      repeat (4) @(negedge clk);
      check("post rst fsel", 32'(field_sel), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 clk  in  1  single system clock; all state on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 key_enter  in  1  asynchronous button level, active-high (board inversion outside block).
REQ-004 key_cancel  in  1  asynchronous button level, active-high.
REQ-005 sw_bcd  in  8  two BCD digits from switches: [7:4] tens, [3:0] units.
REQ-006 load_ready  in  1  clock counter accepts load this cycle.
REQ-007 load_valid  out  1  load request; held until accepted.
REQ-008 load_hr  out  5  binary hours 0-23; load_min, load_sec  out  6 each, binary 0-59.
REQ-009 edit_active  out  1  high in any EDIT state; field_sel  out  2  00 none, 01 hr, 10 min, 11 sec.
REQ-010 err  out  1  last ENTER was rejected.

Function
REQ-011 Each key SHALL pass a 2-flop synchronizer plus a previous-value flop; a press event is sync2=1 and prev=0, i.e. one cycle per press, acted on at the 3rd rising clk edge after the level is first sampled high.
REQ-012 Holding a key SHALL produce exactly one event; release produces none.
REQ-013 FSM states: IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, LOAD.
REQ-014 IDLE + enter -> EDIT_HR; cancel ignored.
REQ-015 EDIT_x + enter with valid sw_bcd -> capture binary value into field x, clear err, advance HR->MIN->SEC->LOAD.
REQ-016 EDIT_x + enter with invalid sw_bcd -> stay, field unchanged, err=1.
REQ-017 Valid: both digits <=9 and value <=23 (hr) or <=59 (min/sec).
REQ-018 Conversion: binary = tens*10 + units, computed in >=7 bits, truncated to field width only after validation.
REQ-019 EDIT_x + cancel -> IDLE, captured fields discarded (load_* return to 0), err cleared.
REQ-020 Cancel and enter events in the same cycle: cancel wins.
REQ-021 LOAD: load_valid=1, load_* stable; load_valid & load_ready on an edge -> IDLE, load_valid=0 next cycle.
REQ-022 LOAD ignores both keys; no timeout.
REQ-023 load_* SHALL hold last committed values in IDLE; change only in EDIT states or reset.
REQ-024 edit_active/field_sel/load_valid decoded directly from registered state (no combinational path from inputs).

Reset
REQ-025 rst asserted at any time, including mid-edit or in LOAD with load_valid=1: state=IDLE, load_valid=0, load_*=0, err=0, field_sel=00, edit_active=0, synchronizer/prev flops=0, within the same cycle (asynchronous).
REQ-026 A key already held when rst deasserts SHALL produce one press event (prev starts at 0).

Structure
REQ-027 Package time_entry_pkg: state enum, HR_MAX=23, MS_MAX=59, field_sel encodings.
REQ-028 Sub-module key_edge (synchronizer + rising-edge pulse), instantiated twice.
REQ-029 BCD validation/conversion a pure function in the package; target 150-250 RTL lines total.

Verification
REQ-030 enter; sw=0x13,enter; sw=0x45,enter; sw=0x07,enter; load_ready=1 -> one load_valid cycle-handshake with hr=13, min=45, sec=7, then IDLE.
REQ-031 EDIT_HR, sw=0x24,enter -> err=1, field_sel=01; sw=0x23,enter -> err=0, field_sel=10.
REQ-032 EDIT_MIN, sw=0x5A,enter -> err=1 (units>9); sw=0x60 -> err=1; sw=0x59 -> accepted.
REQ-033 EDIT_SEC, enter and cancel rising together -> IDLE, load_valid never asserted, load_*=0.
REQ-034 LOAD with load_ready=0 for 10 cycles -> load_valid and load_* stable; rst pulse -> all outputs 0 immediately.
REQ-035 enter held 100 cycles -> exactly one transition; event occurs 3 edges after first high sample.
